// File: rtl/arbitro_rr4_8bits.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_rr4_8bits
//  Purpose  : Merges four lane streams into a single registered output
//             stream. Each lane has a small FIFO, and a round-robin
//             arbiter drains the FIFOs one word per cycle. The output
//             uses a valid/ready handshake. The block also provides
//             per-lane pause outputs and sticky overflow flags.
//  Options  : ARB_FIXED_PRIO_EN - replaces round-robin with fixed
//             priority (lane 0 highest, lane 3 lowest).
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr4_8bits #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = 3
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic              valid_in2,
    input  logic              valid_in3,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        lane_out,
    output logic              pause0,
    output logic              pause1,
    output logic              pause2,
    output logic              pause3,
    output logic [3:0]        err_ovf
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0]  C_AF    = CW'(ALMOST_FULL);

    // Lane inputs gathered into indexable form
    logic [DATA_W-1:0] din_w  [4];
    logic [3:0]        vin_w;

    // Per-lane status and control
    logic [DATA_W-1:0] head_w [4];
    logic [3:0]        nonempty_w;
    logic [3:0]        pop_w;
    logic [3:0]        pause_w;
    logic [3:0]        err_w;

    // Arbitration result
    logic              free_w;
    logic              grant_w;
    logic [1:0]        grant_lane_w;

    // Output stage registers
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [1:0]        lane_q;

    assign din_w[0] = data_in0;
    assign din_w[1] = data_in1;
    assign din_w[2] = data_in2;
    assign din_w[3] = data_in3;
    assign vin_w    = {valid_in3, valid_in2, valid_in1, valid_in0};

    // ------------------------------------------------------------------
    // Lane FIFOs
    // ------------------------------------------------------------------
    generate
        for (genvar n = 0; n < 4; n++) begin : g_lane
            logic [DATA_W-1:0] mem_q [DEPTH];
            logic [CW-1:0]     count_q;
            logic [CW-1:0]     wr_ptr_q;
            logic [CW-1:0]     rd_ptr_q;
            logic              err_q;
            logic              full_w;
            logic              push_w;

            // Fullness is judged on the count at the start of the cycle,
            // so a same-cycle pop does not make room for a new word.
            assign full_w        = (count_q == C_DEPTH);
            assign push_w        = vin_w[n] && !full_w;
            assign nonempty_w[n] = (count_q != '0);
            assign pause_w[n]    = (count_q >= C_AF);
            assign err_w[n]      = err_q;
            assign head_w[n]     = mem_q[rd_ptr_q[AW-1:0]];

            // Pointers, occupancy and the sticky overflow flag
            always_ff @(posedge clk_f or posedge reset) begin
                if (reset) begin
                    count_q  <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    err_q    <= 1'b0;
                end else begin
                    if (push_w) begin
                        wr_ptr_q <= wr_ptr_q + CW'(1);
                    end
                    if (pop_w[n]) begin
                        rd_ptr_q <= rd_ptr_q + CW'(1);
                    end
                    case ({push_w, pop_w[n]})
                        2'b10:   count_q <= count_q + CW'(1);
                        2'b01:   count_q <= count_q - CW'(1);
                        default: count_q <= count_q;
                    endcase
                    if (vin_w[n] && full_w) begin
                        err_q <= 1'b1;
                    end
                end
            end

            // Storage array; contents are discarded logically by the
            // pointer/count reset, so the array itself needs no reset.
            always_ff @(posedge clk_f) begin
                if (push_w) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= din_w[n];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign free_w = !valid_q || ready_out;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-numbered non-empty lane wins
    always_comb begin
        grant_w      = 1'b0;
        grant_lane_w = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (nonempty_w[k]) begin
                grant_w      = 1'b1;
                grant_lane_w = 2'(k);
            end
        end
        grant_w = grant_w && free_w;
    end
`else
    logic [1:0] last_q;

    // Round-robin: search from last+1 onward; the descending loop lets
    // the nearest candidate overwrite farther ones.
    always_comb begin
        logic [1:0] idx;
        grant_w      = 1'b0;
        grant_lane_w = 2'd0;
        idx          = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (nonempty_w[idx]) begin
                grant_w      = 1'b1;
                grant_lane_w = idx;
            end
        end
        grant_w = grant_w && free_w;
    end

    // Round-robin pointer moves only on a grant
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            last_q <= 2'd3;
        end else if (grant_w) begin
            last_q <= grant_lane_w;
        end
    end
`endif

    assign pop_w = grant_w ? (4'b0001 << grant_lane_w) : 4'b0000;

    // ------------------------------------------------------------------
    // Output register: loads the granted head word when free
    // ------------------------------------------------------------------
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            lane_q  <= 2'd0;
        end else if (free_w) begin
            if (grant_w) begin
                data_q  <= head_w[grant_lane_w];
                lane_q  <= grant_lane_w;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_out  = lane_q;
    assign pause0    = pause_w[0];
    assign pause1    = pause_w[1];
    assign pause2    = pause_w[2];
    assign pause3    = pause_w[3];
    assign err_ovf   = err_w;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr4_8bits.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_rr4_8bits
//  Purpose  : Directed self-checking bench for arbitro_rr4_8bits. The
//             expected values are hand-derived. The bench also follows
//             ARB_FIXED_PRIO_EN where the expectations differ.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr4_8bits;

    logic       clk_f = 1'b0;
    logic       reset;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       valid_in0, valid_in1, valid_in2, valid_in3;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;
    logic       pause0, pause1, pause2, pause3;
    logic [3:0] err_ovf;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    arbitro_rr4_8bits #(
        .DATA_W      (8),
        .DEPTH       (4),
        .ALMOST_FULL (3)
    ) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .valid_in0 (valid_in0),
        .valid_in1 (valid_in1),
        .valid_in2 (valid_in2),
        .valid_in3 (valid_in3),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .pause0    (pause0),
        .pause1    (pause1),
        .pause2    (pause2),
        .pause3    (pause3),
        .err_ovf   (err_ovf)
    );

    always #5 clk_f = ~clk_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(data_out),  32'h00);
        check({tag, "_valid"}, 32'(valid_out), 32'h0);
        check({tag, "_lane"},  32'(lane_out),  32'h0);
        check({tag, "_pause"}, 32'({pause3, pause2, pause1, pause0}), 32'h0);
        check({tag, "_err"},   32'(err_ovf),   32'h0);
    endtask

    // Asynchronous pulse placed between clock edges; outputs are checked
    // while reset is still high, before any edge occurs.
    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1 check_reset_outputs(tag);
        #2 reset = 1'b0;
    endtask

    task automatic idle_inputs();
        valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ready_out = 1'b1;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        idle_inputs();
        #2 check_reset_outputs("init");
        #1 reset = 1'b0;

        // ---------------- single lane ----------------
        data_in2 = 8'hA5; valid_in2 = 1'b1;
        tick();                                   // edge 1: push
        valid_in2 = 1'b0;
        check("single_nobypass", 32'(valid_out), 32'h0);
        tick();                                   // edge 2: granted
        check("single_valid", 32'(valid_out), 32'h1);
        check("single_data",  32'(data_out),  32'hA5);
        check("single_lane",  32'(lane_out),  32'h2);
        tick();                                   // edge 3: drained
        check("single_empty", 32'(valid_out), 32'h0);
        check("single_hold",  32'(data_out),  32'hA5);

        async_reset_pulse("rst_a");

        // ---------------- rotation ----------------
        data_in0 = 8'h10; data_in1 = 8'h11; data_in2 = 8'h12; data_in3 = 8'h13;
        valid_in0 = 1'b1; valid_in1 = 1'b1; valid_in2 = 1'b1; valid_in3 = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rot%0d_valid", i), 32'(valid_out), 32'h1);
`ifdef ARB_FIXED_PRIO_EN
            check($sformatf("rot%0d_data", i), 32'(data_out), 32'(8'h10 + i));
            check($sformatf("rot%0d_lane", i), 32'(lane_out), 32'(i));
`else
            check($sformatf("rot%0d_data", i), 32'(data_out), 32'(8'h10 + i));
            check($sformatf("rot%0d_lane", i), 32'(lane_out), 32'(i));
`endif
        end
        tick();
        check("rot_done", 32'(valid_out), 32'h0);

        // ---------------- backpressure and overflow ----------------
        ready_out = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            data_in1 = 8'(i); valid_in1 = 1'b1;
            tick();
            if (i >= 2) begin
                check($sformatf("bp%0d_data", i), 32'(data_out), 32'h01);
                check($sformatf("bp%0d_lane", i), 32'(lane_out), 32'h1);
            end
            // Count after edge i: 1,1,2,3,4,4 -> pause from edge 4
            check($sformatf("bp%0d_pause1", i), 32'(pause1), (i >= 4) ? 32'h1 : 32'h0);
            check($sformatf("bp%0d_err", i), 32'(err_ovf), (i == 6) ? 32'h2 : 32'h0);
        end
        idle_inputs();
        ready_out = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            check($sformatf("drain%0d_data", i), 32'(data_out), 32'(i));
            check($sformatf("drain%0d_valid", i), 32'(valid_out), 32'h1);
            // Count after successive pops: 3,2,1,0
            check($sformatf("drain%0d_pause1", i), 32'(pause1), (i == 2) ? 32'h1 : 32'h0);
        end
        tick();
        check("drain_empty", 32'(valid_out), 32'h0);
        check("drain_err_sticky", 32'(err_ovf), 32'h2);

        // ---------------- fairness (lanes 0 and 3, last = 1) ----------------
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) begin
                data_in0 = 8'h40 + 8'(i - 1); valid_in0 = 1'b1;
                data_in3 = 8'h70 + 8'(i - 1); valid_in3 = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
            if (i == 1) begin
                check("fair1_valid", 32'(valid_out), 32'h0);
            end else begin
`ifdef ARB_FIXED_PRIO_EN
                check($sformatf("fair%0d_lane", i), 32'(lane_out), 32'h0);
                check($sformatf("fair%0d_data", i), 32'(data_out), 32'(8'h40 + i - 2));
`else
                // Search starts at lane 2, so lane 3 goes first, then alternates
                check($sformatf("fair%0d_lane", i), 32'(lane_out), (i % 2 == 0) ? 32'h3 : 32'h0);
                check($sformatf("fair%0d_data", i), 32'(data_out),
                      (i % 2 == 0) ? 32'(8'h70 + (i - 2) / 2) : 32'(8'h40 + (i - 3) / 2));
`endif
            end
            if (i == 5) begin
                check("fair5_pause3", 32'(pause3), 32'h1);
`ifdef ARB_FIXED_PRIO_EN
                check("fair5_err", 32'(err_ovf), 32'hA);
`else
                check("fair5_pause0", 32'(pause0), 32'h1);
                check("fair5_err", 32'(err_ovf), 32'h2);
`endif
            end
        end
        tick();
`ifdef ARB_FIXED_PRIO_EN
        check("fair7_lane", 32'(lane_out), 32'h3);
        check("fair7_data", 32'(data_out), 32'h70);
`else
        check("fair7_lane", 32'(lane_out), 32'h0);
        check("fair7_data", 32'(data_out), 32'h42);
`endif

        // ---------------- reset mid-stream ----------------
        ready_out = 1'b0;
        async_reset_pulse("rst_mid");
        ready_out = 1'b1;
        tick();
        check("post_rst_valid1", 32'(valid_out), 32'h0);
        tick();
        check("post_rst_valid2", 32'(valid_out), 32'h0);
        check("post_rst_data",   32'(data_out),  32'h00);
        check("post_rst_err",    32'(err_ovf),   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
